// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: internal memory port between the AHB slave (master side) and its memory responder
interface ahb_slave_mem_if #(
    parameter int ADDR_BITS = 12
);
    logic                 CLR;
    logic                 WR;
    logic [ADDR_BITS-1:0] ADDR_WR;
    logic [31:0]          DIN;
    logic [3:0]           BSEL;
    logic                 RD;
    logic [ADDR_BITS-1:0] ADDR_RD;
    logic [31:0]          DOUT;
    logic                 BUSY;
    logic                 ERR;
    logic [15:0]          WR_CNT;
    logic [15:0]          RD_CNT;

    modport master (
        output CLR, WR, ADDR_WR, DIN, BSEL, RD, ADDR_RD,
        input  DOUT, BUSY, ERR, WR_CNT, RD_CNT
    );
    modport slave (
        input  CLR, WR, ADDR_WR, DIN, BSEL, RD, ADDR_RD,
        output DOUT, BUSY, ERR, WR_CNT, RD_CNT
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: byte-enable word memory with post-reset clear sequencer, range checking and access counters
module ahb_slave_mem #(
    parameter int          ADDR_BITS = 12,
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] CLR_VAL   = 32'h0000_0000,
    parameter logic [31:0] OOR_VAL   = 32'hDEAD_BEEF
) (
    input logic            clk,
    input logic            reset,
    ahb_slave_mem_if.slave bus
);
    localparam int PW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [PW-1:0] LAST = PW'(MEM_WORDS - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [31:0]     r_mem [MEM_WORDS];
    logic [31:0]     r_dout;
    logic            r_busy;
    logic            r_err;
    logic [15:0]     r_wr_cnt;
    logic [15:0]     r_rd_cnt;

    logic [ADDR_BITS-3:0] w_wi, w_ri;
    logic [PW-1:0]        w_wa, w_ra;
    logic                 w_act, w_wr_in, w_rd_in, w_wr_ok, w_rd_ok;
    logic [31:0]          w_old, w_wdata, w_rdata;

    assign w_wi    = bus.ADDR_WR[ADDR_BITS-1:2];
    assign w_ri    = bus.ADDR_RD[ADDR_BITS-1:2];
    assign w_wa    = w_wi[PW-1:0];
    assign w_ra    = w_ri[PW-1:0];
    assign w_wr_in = 32'(w_wi) < MEM_WORDS;
    assign w_rd_in = 32'(w_ri) < MEM_WORDS;
    assign w_act   = (r_state == READY) && !bus.CLR;
    assign w_wr_ok = w_act && bus.WR && w_wr_in;
    assign w_rd_ok = w_act && bus.RD && w_rd_in;
    assign w_old   = r_mem[w_wa];

    always_comb begin
        w_wdata = w_old;
        for (int b = 0; b < 4; b++)
            w_wdata[8*b +: 8] = bus.BSEL[b] ? bus.DIN[8*b +: 8] : w_old[8*b +: 8];
    end

    // write-first: a read of the word being written sees the merged value
    assign w_rdata = (w_wr_ok && w_wa == w_ra) ? w_wdata : r_mem[w_ra];

    always_ff @(posedge clk)
        if (r_state == CLEAR)
            r_mem[r_ptr] <= CLR_VAL;
        else if (w_wr_ok)
            r_mem[w_wa] <= w_wdata;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state  <= CLEAR;
            r_ptr    <= '0;
            r_busy   <= 1'b1;
            r_err    <= 1'b0;
            r_dout   <= '0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_err <= w_act && ((bus.WR && !w_wr_in) || (bus.RD && !w_rd_in));
            if (bus.CLR) begin
                r_state <= CLEAR;
                r_ptr   <= '0;
                r_busy  <= 1'b1;
            end else if (r_state == CLEAR) begin
                r_ptr <= r_ptr + 1'b1;
                if (r_ptr == LAST) begin
                    r_state <= READY;
                    r_busy  <= 1'b0;
                end
            end else begin
                if (w_wr_ok)
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                if (bus.RD)
                    r_dout <= w_rd_in ? w_rdata : OOR_VAL;
                if (w_rd_ok)
                    r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end

    assign bus.DOUT   = r_dout;
    assign bus.BUSY   = r_busy;
    assign bus.ERR    = r_err;
    assign bus.WR_CNT = r_wr_cnt;
    assign bus.RD_CNT = r_rd_cnt;
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- Memory responder at the far end of the AHB slave's internal memory port (WR/ADDR_WR/DIN/BSEL write side, RD/ADDR_RD/DOUT read side).
- Stores words with byte-enable writes and returns read data one clock after the read strobe, which is the timing the slave and its trace monitor sample.
- Includes a post-reset clear sequencer, out-of-range detection and access counters, so simulation benches and FPGA builds get a deterministic, observable memory.

Parameters:
- ADDR_BITS, 12, byte-address width of ADDR_WR/ADDR_RD; word index = ADDR[ADDR_BITS-1:2].
- MEM_WORDS, 1024, implemented words (≤ 2^(ADDR_BITS-2)); word index ≥ MEM_WORDS is out of range.
- CLR_VAL, 32'h0000_0000, value written to every word by the clear sequencer.
- OOR_VAL, 32'hDEAD_BEEF, DOUT value returned for out-of-range reads.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- CLR  in  1  single-cycle pulse; restarts the clear sequence.
- WR  in  1  write strobe, one word per cycle.
- ADDR_WR  in  ADDR_BITS  write byte address.
- DIN  in  32  write data.
- BSEL  in  4  byte enables; bit n covers DIN[8n+7:8n].
- RD  in  1  read strobe.
- ADDR_RD  in  ADDR_BITS  read byte address.
- DOUT  out  32  read data (registered).
- BUSY  out  1  high while clearing.
- ERR  out  1  one-cycle pulse on any out-of-range access.
- WR_CNT  out  16  count of accepted writes (wraps).
- RD_CNT  out  16  count of accepted reads (wraps).

Behaviour:
- Reset values (asynchronous): DOUT=0, BUSY=1, ERR=0, WR_CNT=0, RD_CNT=0, FSM=CLEAR, clear pointer=0. Array contents are not reset directly.
- FSM states:
  - CLEAR: writes CLR_VAL to word[ptr] each cycle and increments ptr. When ptr==MEM_WORDS-1 is written, go to READY and drop BUSY on the next edge. Total BUSY duration is MEM_WORDS cycles after reset release.
  - READY: normal operation. CLR=1 → CLEAR with ptr=0, BUSY=1 from the next edge.
- CLR asserted while already in CLEAR restarts ptr at 0.
- During CLEAR, WR and RD are ignored: no array change, DOUT holds, counters hold, ERR=0.
- Write (READY, WR=1, in range) at edge N: bytes with BSEL[n]=1 updated, others kept; WR_CNT+1. BSEL=0 still counts as an accepted write but changes nothing.
- Read (READY, RD=1, in range) at edge N: DOUT=word[ADDR_RD index] registered at edge N, valid from edge N until the next accepted read. One-cycle latency; RD_CNT+1. DOUT holds when RD=0.
- ADDR bits [1:0] are ignored on both ports.
- Simultaneous WR and RD to the same word: write-first. DOUT returns the merged word (new bytes where BSEL=1, old bytes elsewhere). WR and RD to different words are independent.
- Out of range write: array unchanged, WR_CNT unchanged, ERR=1 next cycle.
- Out of range read: DOUT=OOR_VAL, RD_CNT unchanged, ERR=1 next cycle. If both accesses are out of range, ERR is still a single-cycle pulse.
- Counters wrap 16'hFFFF→0.
- Reset asserted mid-operation: all outputs return to reset values immediately, and a full clear restarts after release.

Test Plan:
- Release reset → BUSY high exactly MEM_WORDS cycles (1024), then low. A read of 0x010 returns 0x00000000 next cycle; RD_CNT=1.
- Write 0x11223344 to 0x020 with BSEL=4'hF, then BSEL=4'b0101 with DIN=0xAABBCCDD → read 0x020 gives DOUT=0x11BB33DD one cycle after RD; WR_CNT=2.
- Same cycle: WR 0x040 DIN=0xCAFEF00D BSEL=4'b0011, RD 0x040 (old value 0) → DOUT=0x0000F00D at that edge.
- With MEM_WORDS=1024, ADDR_BITS=13: write 0x1000 then read 0x1004 → ERR pulses each time, DOUT=0xDEADBEEF, both counters unchanged, address 0x000 unaffected.
- After several writes, pulse CLR and issue WR/RD during BUSY → accesses ignored, DOUT holds. After BUSY falls, every previously written address reads CLR_VAL.
- Assert reset mid-clear (ptr≈500) for 2 cycles → DOUT=0, counters 0, BUSY stays high a full 1024 cycles after release.
